// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   - access size codes carried on req_size
//   - responder FSM state encoding
//   - helpers for size classification and alignment checking
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        if (size[1]) begin
            return lsb != 2'b00;
        end else if (size == SZ_HALF) begin
            return lsb[0];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_responder_lane_merge.sv
// lane_merge: combinational byte-lane steering for the memory responder.
// Lanes are little-endian (lane n = bits [8n+7:8n]).
// Ports:
//   old_word   in  32  word currently held in RAM
//   wdata      in  32  right-aligned store data
//   size       in   2  access size code (SZ_BYTE/SZ_HALF/word)
//   lsb        in   2  byte address bits [1:0]
//   sign_ext   in   1  1 = sign-extend loads, 0 = zero-extend
//   load_data  out 32  addressed lane(s) of old_word, extended
//   store_word out 32  old_word with the addressed lane(s) replaced by wdata
module lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = old_word[7:0];
        half_sel   = old_word[15:0];
        load_data  = old_word;
        store_word = wdata;

        case (lsb)
            2'd0:    byte_sel = old_word[7:0];
            2'd1:    byte_sel = old_word[15:8];
            2'd2:    byte_sel = old_word[23:16];
            default: byte_sel = old_word[31:24];
        endcase

        // Only addr[1] picks the half; addr[0] never matters here.
        half_sel = lsb[1] ? old_word[31:16] : old_word[15:0];

        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                store_word = old_word;
                case (lsb)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data  = {{16{sign_ext & half_sel[15]}}, half_sel};
                store_word = old_word;
                if (lsb[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0]  = wdata[15:0];
                end
            end
            default: begin
                load_data  = old_word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for CPU load/store requests on top of
// a word-wide synchronous RAM. Adds byte/half/word access with sign/zero
// extension; sub-word stores are read-modify-write.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   - misaligned half/word requests skip the RAM and respond with
//               resp_err=1, resp_rdata=0.
//   undefined - resp_err tied 0; low address bits ignored for half/word.
//
// Parameter READ_WAIT (>=1): cycles ram_addr is held before ram_rdata is used.
//
// Ports:
//   clock, reset (async, active-high)
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata
//                         CPU request side
//   resp_valid/resp_rdata/resp_err   CPU response side (registered)
//   ram_addr/ram_wr/ram_wdata/ram_rdata  RAM side
//
// state   | meaning
// IDLE    | ready for a request
// RD_WAIT | RAM address held, waiting READ_WAIT cycles for the old word
// WRITE   | single-cycle RAM write of the (merged) word
// RESP    | one-cycle response pulse
module mem_responder #(
    parameter int READ_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    import mem_pkg::*;

    localparam int              CNT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

    logic [1:0]       state_q,      state_d;
    logic [31:0]      ram_addr_q,   ram_addr_d;
    logic [1:0]       lsb_q,        lsb_d;
    logic [1:0]       size_q,       size_d;
    logic             signed_q,     signed_d;
    logic             write_q,      write_d;
    logic [31:0]      wdata_q,      wdata_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [31:0]      ram_wdata_q,  ram_wdata_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
`ifdef ALIGN_CHECK_EN
    logic             resp_err_q,   resp_err_d;
`endif

    logic        misalign;
    logic [31:0] load_data;
    logic [31:0] store_word;

`ifdef ALIGN_CHECK_EN
    assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // ram_rdata is the old word at the end of RD_WAIT; it feeds both the
    // load extraction and the RMW merge.
    lane_merge u_lane_merge (
        .old_word   (ram_rdata),
        .wdata      (wdata_q),
        .size       (size_q),
        .lsb        (lsb_q),
        .sign_ext   (signed_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        lsb_d        = lsb_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        ram_wdata_d  = ram_wdata_q;
        resp_rdata_d = resp_rdata_q;
`ifdef ALIGN_CHECK_EN
        resp_err_d   = resp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    lsb_d    = req_addr[1:0];
                    if (misalign) begin
                        // Straight to the response; the RAM is never touched.
                        state_d      = RESP;
                        resp_rdata_d = '0;
`ifdef ALIGN_CHECK_EN
                        resp_err_d   = 1'b1;
`endif
                    end else begin
                        ram_addr_d = {req_addr[31:2], 2'b00};
                        if (req_write && is_word(req_size)) begin
                            // Full-word store needs no old data.
                            state_d     = WRITE;
                            ram_wdata_d = req_wdata;
                        end else begin
                            state_d = RD_WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        state_d     = WRITE;
                        ram_wdata_d = store_word;
                    end else begin
                        state_d      = RESP;
                        resp_rdata_d = load_data;
`ifdef ALIGN_CHECK_EN
                        resp_err_d   = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_rdata_d = '0;
`ifdef ALIGN_CHECK_EN
                resp_err_d   = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_addr_q   <= '0;
            lsb_q        <= '0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            ram_wdata_q  <= '0;
            resp_rdata_q <= '0;
`ifdef ALIGN_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            lsb_q        <= lsb_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef ALIGN_CHECK_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // Strobes decode straight from the state flop so an async reset drops
    // ram_wr in the same cycle, before any partial write can land.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign ram_wr     = (state_q == WRITE);
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign resp_rdata = resp_rdata_q;
`ifdef ALIGN_CHECK_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int RW = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] tb_mem    [0:63];
    logic [31:0] model_mem [0:63];
    logic        force_ff = 1'b1;

    // expectation of the request in flight
    bit          active = 0;
    int          acc_n = 0;
    int          lat = 0;
    bit          has_wr = 0;
    bit          exp_err = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_waddr = '0;
    logic [31:0] hold_rdata = '0;
    logic        hold_err = 1'b0;

    int          wr_count = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    mem_responder #(.READ_WAIT(RW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM stand-in: read data follows the held address, writes on the edge.
    assign ram_rdata = force_ff ? 32'hFFFF_FFFF : tb_mem[ram_addr[7:2]];
    always @(posedge clock) if (ram_wr) tb_mem[ram_addr[7:2]] <= ram_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the expectation of the request in flight
    always @(negedge clock) begin
        bit in_fl, v_exp, w_exp, a_exp;
        if (reset) begin
            chk1("rst_req_ready", req_ready, 1'b1);
            chk1("rst_resp_valid", resp_valid, 1'b0);
            chk1("rst_ram_wr", ram_wr, 1'b0);
            chk1("rst_resp_err", resp_err, 1'b0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_ram_addr", ram_addr, 32'h0);
            chk("rst_ram_wdata", ram_wdata, 32'h0);
            hold_rdata = '0;
            hold_err   = 1'b0;
        end else begin
            in_fl = active && (cyc > acc_n) && (cyc <= acc_n + lat);
            v_exp = active && (cyc == acc_n + lat);
            w_exp = active && has_wr && (cyc == acc_n + lat - 1);
            a_exp = in_fl && !exp_err && (cyc < acc_n + lat);
            if (v_exp) begin
                hold_rdata = exp_rdata;
                hold_err   = exp_err;
            end
            chk1("req_ready", req_ready, !in_fl);
            chk1("resp_valid", resp_valid, v_exp);
            chk("resp_rdata", resp_rdata, hold_rdata);
            chk1("resp_err", resp_err, hold_err);
            chk1("ram_wr", ram_wr, w_exp);
            if (a_exp) chk("ram_addr", ram_addr, exp_waddr);
            if (w_exp) chk("ram_wdata", ram_wdata, exp_wdata);
        end
        if (ram_wr) begin
            wr_count++;
            last_wr_addr = ram_addr;
            last_wr_data = ram_wdata;
        end
        if (resp_valid) begin
            last_rdata = resp_rdata;
            last_err   = resp_err;
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit noise, input bit abort);
        logic [31:0] old, mw, topb, v, nw;
        int sh, k, l;
        bit err;
        @(negedge clock); #1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clock); #1;
            k++;
        end
        if (!req_ready) begin
            chk1("ready_timeout", req_ready, 1'b1);
            return;
        end
        old = model_mem[a[7:2]];
`ifdef ALIGN_CHECK_EN
        err = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        err = 0;
`endif
        case (sz)
            2'b00:   begin mw = 32'h0000_00FF; sh = 8 * int'(a[1:0]); end
            2'b01:   begin mw = 32'h0000_FFFF; sh = 16 * int'(a[1]); end
            default: begin mw = 32'hFFFF_FFFF; sh = 0; end
        endcase
        topb = mw ^ (mw >> 1);
        v = (old >> sh) & mw;
        if (sg && ((v & topb) != 0)) v = v | ~mw;
        nw = (old & ~(mw << sh)) | ((wd & mw) << sh);
        if (err)         l = 1;
        else if (!w)     l = RW + 1;
        else if (sz[1])  l = 2;
        else             l = RW + 2;

        lat       = l;
        exp_err   = err;
        has_wr    = w && !err;
        exp_rdata = (err || w) ? 32'h0 : v;
        exp_wdata = nw;
        exp_waddr = {a[31:2], 2'b00};
        acc_n     = cyc;
        active    = 1;

        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clock); #1;
        if (noise) begin
            // garbage request held while busy must be ignored
            req_addr  = a ^ 32'h0000_0104;
            req_write = ~w;
            repeat (l - 1) @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        req_write = 1'b0;

        if (abort) begin
            while (cyc < acc_n + l - 1) @(negedge clock);
            #1;
            reset  = 1'b1;
            active = 0;
            #1;
            chk1("abort_ram_wr_drop", ram_wr, 1'b0);
            chk1("abort_no_resp", resp_valid, 1'b0);
            @(negedge clock);
            @(negedge clock); #1;
            reset = 1'b0;
            repeat (3) @(negedge clock);
            #1;
            chk1("abort_ready_after", req_ready, 1'b1);
            return;
        end
        if (has_wr) model_mem[a[7:2]] = nw;
        repeat (l + 1) @(negedge clock);
    endtask

    initial begin
        int n;
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]    = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
            model_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        tb_mem[1]  = 32'hCAFE_F00D; model_mem[1]  = 32'hCAFE_F00D;
        tb_mem[4]  = 32'h80FF_1234; model_mem[4]  = 32'h80FF_1234;
        tb_mem[8]  = 32'h1122_3344; model_mem[8]  = 32'h1122_3344;
        tb_mem[12] = 32'h5566_7788; model_mem[12] = 32'h5566_7788;

        // reset with RAM data all ones
        repeat (3) @(negedge clock);
        #1;
        chk1("t1_ready", req_ready, 1'b1);
        chk("t1_rdata", resp_rdata, 32'h0);
        force_ff = 1'b0;
        reset    = 1'b0;

        // loads
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 0, 0);
        chk("t2_lb_signed", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 0, 0);
        chk("lbu", last_rdata, 32'h0000_0012);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 0, 0);
        chk("lh_upper", last_rdata, 32'hFFFF_80FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, 1, 0);
        chk("lhu_noise", last_rdata, 32'h0000_1234);

        // half store RMW
        n = wr_count;
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 0, 0);
        chk("t3_wr_count", wr_count, n + 1);
        chk("t3_wr_addr", last_wr_addr, 32'h0000_0020);
        chk("t3_wr_data", last_wr_data, 32'hBEEF_3344);

        // word store, then read back
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 0, 0);
        chk("t4_readback", last_rdata, 32'hDEAD_BEEF);

        // byte store, read back with size code 11
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00C3, 0, 0);
        do_req(1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0, 0, 0);
        chk("sb_size11", last_rdata, 32'hBEEF_C344);

        // reset during the write of a byte store
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00AA, 0, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 0, 0);
        chk("t5_untouched", last_rdata, 32'h5566_7788);

        // misaligned word load
        n = wr_count;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0, 0);
`ifdef ALIGN_CHECK_EN
        chk1("t6_err", last_err, 1'b1);
        chk("t6_rdata", last_rdata, 32'h0);
`else
        chk1("t6_err", last_err, 1'b0);
        chk("t6_rdata", last_rdata, 32'hCAFE_F00D);
`endif
        chk("t6_no_write", wr_count, n);

        // odd half store (misaligned when checking is on)
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0023, 32'h0000_1357, 0, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
